// File: rtl/hmac_link_pkg.sv
// -----------------------------------------------------------------------------
// hmac_link_pkg
// Shared definitions for the HMAC link bridge: byte width, default packet
// sizes, the transmit FSM state encoding and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package hmac_link_pkg;

  localparam int DATA_W            = 8;
  localparam int PKT_IN_BYTES_DEF  = 128;
  localparam int PKT_OUT_BYTES_DEF = 32;

  // Cycles WAIT_BUSY waits for the transmitter to raise txBusy before
  // assuming it either finished instantly or never reported busy.
  localparam int WAIT_BUSY_CYCLES  = 2;

  typedef enum logic [2:0] {
    TX_IDLE      = 3'd0,
    TX_ISSUE     = 3'd1,
    TX_WAIT_BUSY = 3'd2,
    TX_WAIT_DONE = 3'd3,
    TX_GAP1      = 3'd4,
    TX_GAP2      = 3'd5
  } txState_t;

  // Width of a counter running 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WAIT_W = cntWidth(WAIT_BUSY_CYCLES);

endpackage

// File: rtl/hmac_link_tx.sv
// -----------------------------------------------------------------------------
// hmac_link_tx
// Drains result packets from the HMAC core into the UART transmitter, one
// byte at a time, and counts bytes so a pulse marks the end of each packet.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   jobReady     core has a result packet queued
//   coreOut      core byte at its current read pointer (combinational)
//   txBusy       UART transmitter is shifting
//   read         one-cycle pulse advancing the core read pointer
//   txStart      one-cycle pulse starting the UART transmitter
//   txData       byte to transmit, valid from txStart until the next txStart
//   pktSent      one-cycle pulse once the last byte of a packet has completed
// -----------------------------------------------------------------------------
module hmac_link_tx
  import hmac_link_pkg::*;
#(
  parameter int PKT_OUT_BYTES = PKT_OUT_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jobReady,
  input  logic [DATA_W-1:0] coreOut,
  input  logic              txBusy,
  output logic              read,
  output logic              txStart,
  output logic [DATA_W-1:0] txData,
  output logic              pktSent
);

  localparam int                CNT_W     = cntWidth(PKT_OUT_BYTES);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(PKT_OUT_BYTES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_BUSY_CYCLES - 1);

  txState_t          state;
  txState_t          stateNext;
  logic [CNT_W-1:0]  byteCnt;
  logic [WAIT_W-1:0] waitCnt;

  logic lastByte;
  logic busyTimeout;
  logic byteDone;
  logic issueNow;

  assign lastByte    = (byteCnt == LAST_BYTE);
  assign busyTimeout = (waitCnt == WAIT_LAST);
  assign byteDone    = (state == TX_WAIT_DONE) && !txBusy;
  assign issueNow    = (state == TX_IDLE) && (stateNext == TX_ISSUE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TX_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      TX_IDLE:      if (jobReady && !txBusy) stateNext = TX_ISSUE;
      TX_ISSUE:     stateNext = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (txBusy || busyTimeout) stateNext = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!txBusy) stateNext = lastByte ? TX_GAP1 : TX_IDLE;
      TX_GAP1:      stateNext = TX_GAP2;
      TX_GAP2:      stateNext = TX_IDLE;
      default:      stateNext = TX_IDLE;
    endcase
  end

  // Outputs decoded from the current state only, so they drop to zero the
  // instant reset forces the state back to IDLE.
  always_comb begin
    read    = 1'b0;
    txStart = 1'b0;
    pktSent = 1'b0;
    unique case (state)
      TX_ISSUE: begin
        read    = 1'b1;
        txStart = 1'b1;
      end
      TX_GAP1:  pktSent = 1'b1;
      default: begin
        read    = 1'b0;
        txStart = 1'b0;
        pktSent = 1'b0;
      end
    endcase
  end

  // Byte capture, busy-wait timer and output byte counter.
  // txData is loaded on the edge into ISSUE so it is already valid while
  // txStart is high and stays put until the next ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txData  <= '0;
      waitCnt <= '0;
      byteCnt <= '0;
    end else begin
      if (issueNow) begin
        txData <= coreOut;
      end

      if (state == TX_WAIT_BUSY) begin
        waitCnt <= waitCnt + WAIT_W'(1);
      end else begin
        waitCnt <= '0;
      end

      if (byteDone) begin
        byteCnt <= lastByte ? '0 : byteCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hmac_link_bridge.sv
// -----------------------------------------------------------------------------
// hmac_link_bridge
// Glue between a UART and the HMAC core. Received UART bytes are forwarded to
// the core deserializer with one cycle of latency and counted into work
// packets; result bytes are pulled from the core and handed to the UART
// transmitter by hmac_link_tx. The two directions share nothing but the clock.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   rxValid      one-cycle strobe for a received UART byte
//   rxData       received byte, valid with rxValid
//   load         byte strobe to the core deserializer
//   dataOut      byte to the core, valid with load
//   pktLoaded    one-cycle pulse together with the last load of a work packet
//   jobReady     core has a result packet queued
//   coreOut      core byte at its read pointer
//   read         one-cycle pulse advancing the core read pointer
//   txBusy       UART transmitter is shifting
//   txStart      one-cycle pulse starting the UART transmitter
//   txData       byte to transmit
//   pktSent      one-cycle pulse after the last byte of a result packet
// -----------------------------------------------------------------------------
module hmac_link_bridge
  import hmac_link_pkg::*;
#(
  parameter int PKT_IN_BYTES  = PKT_IN_BYTES_DEF,
  parameter int PKT_OUT_BYTES = PKT_OUT_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxValid,
  input  logic [DATA_W-1:0] rxData,
  output logic              load,
  output logic [DATA_W-1:0] dataOut,
  output logic              pktLoaded,
  input  logic              jobReady,
  input  logic [DATA_W-1:0] coreOut,
  output logic              read,
  input  logic              txBusy,
  output logic              txStart,
  output logic [DATA_W-1:0] txData,
  output logic              pktSent
);

  localparam int                  RX_CNT_W = cntWidth(PKT_IN_BYTES);
  localparam logic [RX_CNT_W-1:0] RX_LAST  = RX_CNT_W'(PKT_IN_BYTES - 1);

  logic                vld_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                pktLoaded_p1;
  logic [RX_CNT_W-1:0] rxCnt;
  logic                rxLast;

  assign rxLast = (rxCnt == RX_LAST);

  // RX stage p0 -> p1: one register between the UART and the core, no
  // backpressure. The packet pulse is registered alongside so it lines up
  // with the final load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      pktLoaded_p1 <= 1'b0;
      rxCnt        <= '0;
    end else begin
      vld_p1       <= rxValid;
      data_p1      <= rxData;
      pktLoaded_p1 <= rxValid && rxLast;
      if (rxValid) begin
        rxCnt <= rxLast ? '0 : rxCnt + RX_CNT_W'(1);
      end
    end
  end

  assign load      = vld_p1;
  assign dataOut   = data_p1;
  assign pktLoaded = pktLoaded_p1;

  hmac_link_tx #(
    .PKT_OUT_BYTES (PKT_OUT_BYTES)
  ) uTx (
    .clk      (clk),
    .rst_n    (rst_n),
    .jobReady (jobReady),
    .coreOut  (coreOut),
    .txBusy   (txBusy),
    .read     (read),
    .txStart  (txStart),
    .txData   (txData),
    .pktSent  (pktSent)
  );

endmodule

// File: tb/tb_hmac_link_bridge.sv
`timescale 1ns/1ps
module tb_hmac_link_bridge;

  localparam int IN_B  = 128;
  localparam int OUT_B = 32;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rxValid  = 1'b0;
  logic [7:0] rxData   = 8'h00;
  logic       jobReady = 1'b0;
  logic       load;
  logic [7:0] dataOut;
  logic       pktLoaded;
  logic [7:0] coreOut;
  logic       read;
  logic       txBusy;
  logic       txStart;
  logic [7:0] txData;
  logic       pktSent;

  hmac_link_bridge #(
    .PKT_IN_BYTES  (IN_B),
    .PKT_OUT_BYTES (OUT_B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxValid   (rxValid),
    .rxData    (rxData),
    .load      (load),
    .dataOut   (dataOut),
    .pktLoaded (pktLoaded),
    .jobReady  (jobReady),
    .coreOut   (coreOut),
    .read      (read),
    .txBusy    (txBusy),
    .txStart   (txStart),
    .txData    (txData),
    .pktSent   (pktSent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Environment: core result queue (byte = 0xA0 + index within packet) and a
  // UART transmitter that stays busy for busyLen cycles after each start.
  int readIdx   = 0;
  int readBase  = 0;
  int busyLen   = 10;
  bit busyStuck = 1'b0;
  int busyCnt   = 0;

  always @(posedge clk) begin
    if (read) readIdx <= readIdx + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     busyCnt <= 0;
    else if (txStart && !busyStuck) busyCnt <= busyLen;
    else if (busyCnt > 0)           busyCnt <= busyCnt - 1;
  end

  assign txBusy  = (busyCnt > 0);
  assign coreOut = 8'(160 + ((readIdx - readBase) % OUT_B));

  // Observation of both streams, sampled on the falling edge.
  int         cyc = 0;
  int         txStarts = 0, reads = 0, pktSents = 0, pktLoadeds = 0;
  int         readBad = 0, rxLatErr = 0, pktLoadedBad = 0, pktSentBad = 0;
  int         loadsSinceRst = 0, startsSinceRst = 0;
  logic [7:0] txBytes[$];
  logic [7:0] rxBytes[$];
  int         startCyc[$];
  logic [7:0] lastLoadedData = 8'h00;
  logic       prevV = 1'b0;
  logic [7:0] prevD = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prevV = 1'b0;
      loadsSinceRst = 0;
      startsSinceRst = 0;
    end else begin
      if (txStart) begin
        txBytes.push_back(txData);
        startCyc.push_back(cyc);
        txStarts++;
        startsSinceRst++;
      end
      if (read) begin
        reads++;
        if (!jobReady || !txStart) readBad++;
      end
      if (pktSent) begin
        pktSents++;
        if (startsSinceRst == 0 || (startsSinceRst % OUT_B) != 0) pktSentBad++;
      end
      if (load !== prevV || (prevV && dataOut !== prevD)) rxLatErr++;
      if (load) begin
        rxBytes.push_back(dataOut);
        loadsSinceRst++;
      end
      if (pktLoaded !== (load && (loadsSinceRst % IN_B) == 0)) pktLoadedBad++;
      if (pktLoaded) begin
        pktLoadeds++;
        lastLoadedData = dataOut;
      end
      prevV = rxValid;
      prevD = rxData;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitPktSent(input int target, input int budget, output bit ok);
    int n = 0;
    while (pktSents < target && n < budget) begin
      tick(1);
      n++;
    end
    ok = (pktSents >= target);
  endtask

  task automatic waitStarts(input int target, input int budget, output bit ok);
    int n = 0;
    while (txStarts < target && n < budget) begin
      tick(1);
      n++;
    end
    ok = (txStarts >= target);
  endtask

  task automatic test_reset();
    rxValid  = 1'b1;
    rxData   = 8'h5A;
    jobReady = 1'b1;
    tick(3);
    checks++;
    if ({load, dataOut, pktLoaded} !== 10'd0) $display("FAIL reset_rx: got %h expected 0", {load, dataOut, pktLoaded});
    else passes++;
    checks++;
    if ({read, txStart, txData, pktSent} !== 11'd0) $display("FAIL reset_tx: got %h expected 0", {read, txStart, txData, pktSent});
    else passes++;
    rxValid  = 1'b0;
    rxData   = 8'h00;
    jobReady = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    checks++;
    if ({load, read, txStart, pktSent, pktLoaded} !== 5'd0) $display("FAIL idle_after_reset: got %b expected 00000", {load, read, txStart, pktSent, pktLoaded});
    else passes++;
  endtask

  task automatic test_rx_packet();
    int l0 = rxBytes.size();
    int p0 = pktLoadeds;
    int e0 = rxLatErr;
    int b0 = pktLoadedBad;
    int bad = 0;
    int gap;
    for (int i = 0; i < IN_B; i++) begin
      rxValid = 1'b1;
      rxData  = 8'(i);
      tick(1);
      rxValid = 1'b0;
      gap = int'($urandom_range(0, 2));
      if (gap > 0) tick(gap);
    end
    tick(3);
    checks++;
    if (rxBytes.size() - l0 != IN_B) $display("FAIL rx_count: got %0d expected %0d", rxBytes.size() - l0, IN_B);
    else passes++;
    if (rxBytes.size() - l0 >= IN_B) begin
      for (int i = 0; i < IN_B; i++) if (rxBytes[l0 + i] !== 8'(i)) bad++;
    end else bad = IN_B;
    checks++;
    if (bad != 0) $display("FAIL rx_data: got %0d wrong bytes expected 0", bad);
    else passes++;
    checks++;
    if (pktLoadeds - p0 != 1) $display("FAIL rx_pktLoaded_count: got %0d expected 1", pktLoadeds - p0);
    else passes++;
    checks++;
    if (lastLoadedData !== 8'h7F) $display("FAIL rx_pktLoaded_data: got %h expected 7f", lastLoadedData);
    else passes++;
    checks++;
    if (rxLatErr - e0 != 0) $display("FAIL rx_latency: got %0d errors expected 0", rxLatErr - e0);
    else passes++;
    checks++;
    if (pktLoadedBad - b0 != 0) $display("FAIL rx_pktLoaded_timing: got %0d errors expected 0", pktLoadedBad - b0);
    else passes++;
  endtask

  task automatic test_tx_packet();
    int s0  = txStarts;
    int r0  = reads;
    int p0  = pktSents;
    int rb0 = readBad;
    int sb0 = pktSentBad;
    int bad = 0;
    bit ok;
    busyLen  = 10;
    jobReady = 1'b1;
    waitPktSent(p0 + 1, 1000, ok);
    jobReady = 1'b0;
    tick(30);
    checks++;
    if (!ok) $display("FAIL tx_timeout: got no pktSent expected 1");
    else passes++;
    checks++;
    if (txStarts - s0 != OUT_B) $display("FAIL tx_starts: got %0d expected %0d", txStarts - s0, OUT_B);
    else passes++;
    checks++;
    if (reads - r0 != OUT_B) $display("FAIL tx_reads: got %0d expected %0d", reads - r0, OUT_B);
    else passes++;
    if (txBytes.size() >= s0 + OUT_B) begin
      for (int i = 0; i < OUT_B; i++) if (txBytes[s0 + i] !== 8'(160 + i)) bad++;
    end else bad = OUT_B;
    checks++;
    if (bad != 0) $display("FAIL tx_data: got %0d wrong bytes expected 0", bad);
    else passes++;
    checks++;
    if (pktSents - p0 != 1) $display("FAIL tx_pktSent_count: got %0d expected 1", pktSents - p0);
    else passes++;
    checks++;
    if (readBad - rb0 != 0 || pktSentBad - sb0 != 0) $display("FAIL tx_protocol: got %0d/%0d errors expected 0/0", readBad - rb0, pktSentBad - sb0);
    else passes++;
  endtask

  task automatic test_jobready_stall();
    int s0  = txStarts;
    int r0  = reads;
    int p0  = pktSents;
    int sb0 = pktSentBad;
    int bad = 0;
    bit ok;
    busyLen  = int'($urandom_range(4, 12));
    jobReady = 1'b1;
    waitStarts(s0 + 6, 300, ok);
    jobReady = 1'b0;
    tick(50);
    checks++;
    if (!ok || txStarts - s0 != 6) $display("FAIL stall_starts: got %0d expected 6", txStarts - s0);
    else passes++;
    checks++;
    if (reads - r0 != 6) $display("FAIL stall_reads: got %0d expected 6", reads - r0);
    else passes++;
    jobReady = 1'b1;
    waitPktSent(p0 + 1, 1000, ok);
    jobReady = 1'b0;
    tick(30);
    checks++;
    if (!ok || txStarts - s0 != OUT_B) $display("FAIL stall_total: got %0d expected %0d", txStarts - s0, OUT_B);
    else passes++;
    if (txBytes.size() >= s0 + OUT_B) begin
      for (int i = 0; i < OUT_B; i++) if (txBytes[s0 + i] !== 8'(160 + i)) bad++;
    end else bad = OUT_B;
    checks++;
    if (bad != 0) $display("FAIL stall_data: got %0d wrong bytes expected 0", bad);
    else passes++;
    checks++;
    if (pktSents - p0 != 1 || pktSentBad != sb0) $display("FAIL stall_pktSent: got %0d expected 1", pktSents - p0);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int l0  = rxBytes.size();
    int lp0 = pktLoadeds;
    int e0  = rxLatErr;
    int b0  = pktLoadedBad;
    int s0  = txStarts;
    int p0  = pktSents;
    int bad = 0;
    bit ok  = 1'b0;
    busyLen  = int'($urandom_range(6, 12));
    jobReady = 1'b1;
    fork
      begin
        for (int i = 0; i < 2 * IN_B; i++) begin
          rxValid = 1'b1;
          rxData  = 8'($urandom);
          exp.push_back(rxData);
          tick(1);
        end
        rxValid = 1'b0;
      end
      begin
        waitPktSent(p0 + 1, 2000, ok);
        jobReady = 1'b0;
      end
    join
    tick(30);
    checks++;
    if (rxBytes.size() - l0 != 2 * IN_B) $display("FAIL b2b_rx_count: got %0d expected %0d", rxBytes.size() - l0, 2 * IN_B);
    else passes++;
    if (rxBytes.size() - l0 >= 2 * IN_B) begin
      for (int i = 0; i < 2 * IN_B; i++) if (rxBytes[l0 + i] !== exp[i]) bad++;
    end else bad = 2 * IN_B;
    checks++;
    if (bad != 0) $display("FAIL b2b_rx_data: got %0d wrong bytes expected 0", bad);
    else passes++;
    checks++;
    if (pktLoadeds - lp0 != 2 || pktLoadedBad != b0 || rxLatErr != e0) $display("FAIL b2b_rx_pkt: got %0d pulses expected 2", pktLoadeds - lp0);
    else passes++;
    bad = 0;
    if (txBytes.size() >= s0 + OUT_B) begin
      for (int i = 0; i < OUT_B; i++) if (txBytes[s0 + i] !== 8'(160 + i)) bad++;
    end else bad = OUT_B;
    checks++;
    if (!ok || bad != 0 || txStarts - s0 != OUT_B) $display("FAIL b2b_tx: got %0d starts %0d wrong expected %0d starts 0 wrong", txStarts - s0, bad, OUT_B);
    else passes++;
    checks++;
    if (pktSents - p0 != 1) $display("FAIL b2b_pktSent: got %0d expected 1", pktSents - p0);
    else passes++;
  endtask

  task automatic test_reset_midpacket();
    int s0 = txStarts;
    int sR;
    int p0;
    int bad = 0;
    bit ok;
    busyLen  = 10;
    jobReady = 1'b1;
    rxValid  = 1'b1;
    rxData   = 8'hC3;
    waitStarts(s0 + 11, 500, ok);
    tick(4);
    checks++;
    if (!ok || txData !== 8'hAA || !txBusy) $display("FAIL midpkt_pre: got txData %h expected aa", txData);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({load, dataOut, pktLoaded, read, txStart, txData, pktSent} !== 21'd0)
      $display("FAIL midpkt_reset_outputs: got %h expected 0", {load, dataOut, pktLoaded, read, txStart, txData, pktSent});
    else passes++;
    rxValid  = 1'b0;
    jobReady = 1'b0;
    readBase = readIdx;
    tick(2);
    rst_n = 1'b1;
    sR = txStarts;
    p0 = pktSents;
    tick(5);
    checks++;
    if (txStarts != sR || read !== 1'b0) $display("FAIL midpkt_idle: got %0d starts expected 0", txStarts - sR);
    else passes++;
    jobReady = 1'b1;
    waitPktSent(p0 + 1, 1000, ok);
    jobReady = 1'b0;
    tick(30);
    checks++;
    if (!ok || txStarts - sR != OUT_B || pktSents - p0 != 1) $display("FAIL midpkt_restart: got %0d starts %0d pktSent expected %0d starts 1 pktSent", txStarts - sR, pktSents - p0, OUT_B);
    else passes++;
    if (txBytes.size() >= sR + OUT_B) begin
      for (int i = 0; i < OUT_B; i++) if (txBytes[sR + i] !== 8'(160 + i)) bad++;
    end else bad = OUT_B;
    checks++;
    if (bad != 0 || pktSentBad != 0) $display("FAIL midpkt_data: got %0d wrong bytes %0d misplaced pktSent expected 0", bad, pktSentBad);
    else passes++;
  endtask

  task automatic test_busy_stuck();
    int s0  = txStarts;
    int p0  = pktSents;
    int bad = 0;
    int gapBad = 0;
    bit ok;
    busyStuck = 1'b1;
    jobReady  = 1'b1;
    waitPktSent(p0 + 1, 1000, ok);
    jobReady  = 1'b0;
    tick(30);
    busyStuck = 1'b0;
    checks++;
    if (!ok || txStarts - s0 != OUT_B) $display("FAIL stuck_starts: got %0d expected %0d", txStarts - s0, OUT_B);
    else passes++;
    if (txBytes.size() >= s0 + OUT_B) begin
      for (int i = 0; i < OUT_B; i++) if (txBytes[s0 + i] !== 8'(160 + i)) bad++;
      for (int i = 1; i < OUT_B; i++) if (startCyc[s0 + i] - startCyc[s0 + i - 1] != 5) gapBad++;
    end else begin
      bad = OUT_B;
      gapBad = OUT_B;
    end
    checks++;
    if (bad != 0) $display("FAIL stuck_data: got %0d wrong bytes expected 0", bad);
    else passes++;
    checks++;
    if (gapBad != 0) $display("FAIL stuck_cadence: got %0d byte gaps not 5 cycles expected 0", gapBad);
    else passes++;
    checks++;
    if (pktSents - p0 != 1) $display("FAIL stuck_pktSent: got %0d expected 1", pktSents - p0);
    else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx_packet();
    test_tx_packet();
    test_jobready_stall();
    test_back_to_back();
    test_reset_midpacket();
    test_busy_stuck();
    checks++;
    if (readBad != 0) $display("FAIL read_protocol: got %0d bad read pulses expected 0", readBad);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hmac_link_bridge.md
HMAC_LINK_BRIDGE -- requirements
Module: hmac_link_bridge

Interface
REQ-001 SHALL have parameter PKT_IN_BYTES, default 128, bytes per work packet forwarded to the core.
REQ-002 SHALL have parameter PKT_OUT_BYTES, default 32, bytes per result packet drained from the core.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous, active-low reset.
REQ-005 SHALL have port rxValid, input, 1, a one-cycle strobe marking a received UART byte.
REQ-006 SHALL have port rxData, input, 8, the received byte, valid with rxValid.
REQ-007 SHALL have port load, output, 1, the byte strobe to the core deserializer.
REQ-008 SHALL have port dataOut, output, 8, the byte to the core, valid with load.
REQ-009 SHALL have port pktLoaded, output, 1, a one-cycle pulse when a full work packet has been forwarded.
REQ-010 SHALL have port jobReady, input, 1, the core flag that a result packet is queued.
REQ-011 SHALL have port coreOut, input, 8, the core output byte, combinational from the core read pointer.
REQ-012 SHALL have port read, output, 1, a one-cycle pulse that advances the core read pointer.
REQ-013 SHALL have port txBusy, input, 1, high while the UART transmitter is shifting.
REQ-014 SHALL have port txStart, output, 1, a one-cycle pulse that starts the UART transmitter.
REQ-015 SHALL have port txData, output, 8, the byte to transmit, held stable from txStart until the next txStart.
REQ-016 SHALL have port pktSent, output, 1, a one-cycle pulse after the last byte of a result packet completes.

Function
REQ-017 RX path SHALL register rxValid/rxData to load/dataOut with exactly 1 cycle latency and no backpressure.
REQ-018 RX byte counter SHALL count 0..PKT_IN_BYTES-1, wrap to 0 on the last byte, and assert pktLoaded in the same cycle as that last load.
REQ-019 TX FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP1, GAP2.
REQ-020 IDLE->ISSUE SHALL occur when jobReady=1 and txBusy=0.
REQ-021 ISSUE SHALL last 1 cycle, capture coreOut into txData, and pulse read=1 and txStart=1 in that same cycle.
REQ-022 ISSUE SHALL go to WAIT_BUSY.
REQ-023 WAIT_BUSY SHALL exit on txBusy=1, or after 2 cycles if txBusy never rises; it SHALL then go to WAIT_DONE.
REQ-024 WAIT_DONE SHALL exit on txBusy=0.
REQ-025 On WAIT_DONE exit, if the output byte counter equals PKT_OUT_BYTES-1, the block SHALL clear the counter, pulse pktSent and go to GAP1; otherwise it SHALL increment the counter and return to IDLE.
REQ-026 GAP1->GAP2->IDLE SHALL be unconditional, giving 2 idle cycles so the core queue can pop and jobReady can settle.
REQ-027 If jobReady is 0 in IDLE mid-packet, the FSM SHALL wait without altering the counter.
REQ-028 The block SHALL never pulse read more than once per transmitted byte, and never while jobReady=0.
REQ-029 RX and TX paths SHALL be fully independent; simultaneous rxValid and ISSUE SHALL both be serviced in the same cycle.
REQ-030 Counters SHALL be sized $clog2 of their packet size and SHALL never exceed size-1.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately clear load, dataOut, pktLoaded, read, txStart, txData, pktSent, both counters, and set the FSM to IDLE.
REQ-032 Reset mid-packet SHALL abandon the partial packet with no resync to the core pointer; resync is the host driver's responsibility.

Structure
REQ-033 Shared package hmac_link_pkg SHALL hold the TX state enum and the default packet-size constants 128 and 32.
REQ-034 The TX FSM plus output counter SHALL be sub-module hmac_link_tx; RX logic SHALL stay inline.

Verification
REQ-035 Feed 128 rxValid strobes with bytes 0x00..0x7F -> load mirrors each one cycle later, and pktLoaded pulses once with dataOut=0x7F.
REQ-036 Hold jobReady=1 with coreOut=read-index+0xA0 and a txBusy model of 10 cycles/byte -> exactly 32 txStart pulses carrying 0xA0..0xBF, 32 read pulses, and pktSent once.
REQ-037 Drop jobReady after byte 5 and raise it 50 cycles later -> TX stalls in IDLE, then resumes with byte 6, and the counter is continuous.
REQ-038 Drive rxValid every cycle during a TX packet -> both streams are complete and uncorrupted.
REQ-039 Assert rst_n=0 during WAIT_DONE of byte 10 -> all outputs are 0 within the same cycle, the FSM is IDLE, and the next packet starts at count 0.
REQ-040 Keep txBusy stuck at 0 -> each byte advances via the 2-cycle WAIT_BUSY timeout, and pktSent occurs after 32 bytes.
